sdram_cmd_decoder: RTL
======================

SDRAM_CMD_DECODER -- requirements
Module: sdram_cmd_decoder

Interface
REQ-001 Parameter T_RP, default 2, SHALL set the minimum clocks from PRECHARGE to the next command.
REQ-002 Parameter T_RFC, default 7, SHALL set the minimum clocks from AUTO_REFRESH to the next command.
REQ-003 Parameter T_MRD, default 3, SHALL set the minimum clocks from MODE_REG_SET to the next command.
REQ-004 sys_clk  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-005 sys_rst_n  in  1  asynchronous, active-low reset.
REQ-006 cmd  in  4  {cs_n, ras_n, cas_n, we_n}, sampled every sys_clk.
REQ-007 ba  in  2  bank address bus.
REQ-008 addr  in  12  address bus; addr[10] is the all-bank precharge flag.
REQ-009 cmd_valid  out  1  one-cycle pulse when a non-NOP, non-deselect command is decoded.
REQ-010 cmd_code  out  3  decoded command: 0 PRE, 1 AR, 2 MRS, 3 ACT, 4 RD, 5 WR, 6 BST.
REQ-011 init_seen  out  1  level; the full init sequence has been observed.
REQ-012 mode_reg  out  12  addr value captured at the MRS in the init sequence.
REQ-013 ar_cnt  out  16  count of AUTO_REFRESH commands after init_seen, saturating at 16'hFFFF.
REQ-014 bank_open  out  4  per-bank row-open flags.
REQ-015 viol  out  1  one-cycle violation pulse.
REQ-016 viol_code  out  3  1 TIMING, 2 SEQ, 3 NO_ROW, 4 ROW_OPEN, 5 AR_OPEN; held until the next viol.

Function
REQ-017 Decode SHALL be: cs_n=1 deselect; 0111 NOP; 0010 PRE; 0001 AR; 0000 MRS; 0011 ACT; 0101 RD; 0100 WR; 0110 BST.
REQ-018 All outputs SHALL be registered, with one-cycle latency from the sampled command.
REQ-019 A timing counter SHALL load T_x-1 when PRE, AR or MRS is sampled and SHALL decrement to 0 saturating.
REQ-020 A command sampled while the counter is nonzero SHALL give viol with code TIMING, and it SHALL still be decoded; example: AR at cycle 0 means a command at cycle 7 is legal and one at cycle 6 is not.
REQ-021 The init FSM SHALL have states S_PRE -> S_AR1 -> S_AR2 -> S_MRS -> S_READY.
- S_PRE requires PRE with addr[10]=1.
- S_AR1 and S_AR2 each require AR.
- S_MRS requires MRS, which captures mode_reg.
- Entering S_READY sets init_seen.
REQ-022 A wrong command in any init state SHALL give viol with code SEQ, and the FSM SHALL stay in that state.
REQ-023 When TIMING and SEQ occur together, viol_code SHALL report TIMING.
REQ-024 In S_READY, ACT SHALL set bank_open[ba]; ACT to an already-open bank SHALL give ROW_OPEN.
REQ-025 PRE SHALL clear bank_open[ba], or all four flags when addr[10]=1.
REQ-026 RD or WR to a closed bank SHALL give NO_ROW.
REQ-027 AR with any bank open SHALL give AR_OPEN; ar_cnt SHALL still increment.
REQ-028 When several conditions are true in one cycle, viol_code SHALL be the lowest code.
REQ-029 An MRS in S_READY SHALL update mode_reg, and SHALL give ROW_OPEN if any bank is open.

Reset
REQ-030 On reset assertion, the module SHALL asynchronously clear all outputs, the timing counter and bank_open, and SHALL set the FSM to S_PRE.
REQ-031 If reset asserts mid-sequence, init SHALL restart from S_PRE after release.

Structure
REQ-032 A shared package sdram_pkg SHALL hold the command encodings, the cmd_code values, the viol_code values and the FSM state enum.
REQ-033 The timing counter SHALL be the sub-module sdram_tmr, with load, load value and busy outputs.

Verification
REQ-034 Init sequence: PRE (A10=1), 2 NOP, AR, 7 NOP, AR, 7 NOP, MRS addr=12'h027 -> init_seen=1, mode_reg=12'h027, no viol.
REQ-035 Early refresh: in S_AR2, AR issued 6 cycles after the prior AR -> viol=1, viol_code=1, and the FSM advances.
REQ-036 Row rules: ACT ba=2, then RD ba=1 -> NO_ROW; ACT ba=2 again -> ROW_OPEN; PRE A10=1 -> bank_open=4'h0.
REQ-037 Init order: AR before PRE -> SEQ, init_seen=0; a correct sequence afterwards completes init.
REQ-038 Refresh count: 3 legal ARs in S_READY -> ar_cnt=3; ar_cnt preset near 16'hFFFF saturates.
REQ-039 Reset: reset pulsed while in S_AR2 -> all outputs 0, and a full init is required again.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM command decoder: bus widths, raw command
// encodings {cs_n, ras_n, cas_n, we_n}, decoded command codes, violation codes,
// the init-sequence state enum and the command decode helper.
package sdram_pkg;

  localparam int unsigned CMD_W    = 4;
  localparam int unsigned BA_W     = 2;
  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned NBANK    = 4;
  localparam int unsigned AR_CNT_W = 16;
  localparam int unsigned TMR_W    = 8;
  localparam int unsigned A10      = 10;

  localparam logic [CMD_W-1:0] CMD_NOP = 4'b0111;
  localparam logic [CMD_W-1:0] CMD_PRE = 4'b0010;
  localparam logic [CMD_W-1:0] CMD_AR  = 4'b0001;
  localparam logic [CMD_W-1:0] CMD_MRS = 4'b0000;
  localparam logic [CMD_W-1:0] CMD_ACT = 4'b0011;
  localparam logic [CMD_W-1:0] CMD_RD  = 4'b0101;
  localparam logic [CMD_W-1:0] CMD_WR  = 4'b0100;
  localparam logic [CMD_W-1:0] CMD_BST = 4'b0110;

  typedef enum logic [2:0] {
    CC_PRE = 3'd0, CC_AR = 3'd1, CC_MRS = 3'd2, CC_ACT = 3'd3,
    CC_RD  = 3'd4, CC_WR = 3'd5, CC_BST = 3'd6
  } cmd_code_e;

  typedef enum logic [2:0] {
    VC_NONE = 3'd0, VC_TIMING = 3'd1, VC_SEQ = 3'd2, VC_NO_ROW = 3'd3,
    VC_ROW_OPEN = 3'd4, VC_AR_OPEN = 3'd5
  } viol_code_e;

  typedef enum logic [2:0] {
    S_PRE = 3'd0, S_AR1 = 3'd1, S_AR2 = 3'd2, S_MRS = 3'd3, S_READY = 3'd4
  } init_state_e;

  typedef struct packed {
    logic      valid;
    cmd_code_e code;
  } cmd_dec_t;

  // Deselect (cs_n=1), NOP and unknown patterns all decode as not valid.
  function automatic cmd_dec_t decode_cmd(input logic [CMD_W-1:0] c);
    cmd_dec_t r;
    r.valid = 1'b1;
    r.code  = CC_PRE;
    case (c)
      CMD_PRE: r.code = CC_PRE;
      CMD_AR:  r.code = CC_AR;
      CMD_MRS: r.code = CC_MRS;
      CMD_ACT: r.code = CC_ACT;
      CMD_RD:  r.code = CC_RD;
      CMD_WR:  r.code = CC_WR;
      CMD_BST: r.code = CC_BST;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sdram_cmd_decoder_if.sv
// SDRAM command bus as seen by the decoder.
//   cmd       {cs_n, ras_n, cas_n, we_n}
//   ba        bank address
//   addr      address bus (addr[10] = all-bank precharge flag)
//   ar_ld     preload strobe for the refresh counter (bring-up hook)
//   ar_ld_val value loaded into the refresh counter when ar_ld is high
interface sdram_cmd_decoder_if;
  import sdram_pkg::*;

  logic [CMD_W-1:0]    cmd;
  logic [BA_W-1:0]     ba;
  logic [ADDR_W-1:0]   addr;
  logic                ar_ld;
  logic [AR_CNT_W-1:0] ar_ld_val;

  modport master (output cmd, ba, addr, ar_ld, ar_ld_val);
  modport slave  (input  cmd, ba, addr, ar_ld, ar_ld_val);
endinterface

// File: rtl/sdram_tmr.sv
// Command-spacing timer: loads on PRE/AR/MRS, counts down to 0 and holds.
//   load/load_val  reload request and value (value = required gap - 1)
//   busy           registered, high while the count is nonzero
module sdram_tmr #(
  parameter int unsigned W = 8
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         busy
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         busy_q, busy_d;

  // Reload wins over decrement; decrement saturates at 0.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/sdram_cmd_decoder.sv
// Passive SDRAM command decoder / protocol checker.
//   sys_clk, sys_rst_n  clock, async active-low reset
//   bus                 command bus (slave modport)
//   cmd_valid/cmd_code  one-cycle pulse + code of each decoded command
//   init_seen/mode_reg  init sequence complete / captured mode register
//   ar_cnt              saturating count of refreshes after init
//   bank_open           per-bank row-open flags
//   viol/viol_code      violation pulse / sticky code of last violation
module sdram_cmd_decoder
  import sdram_pkg::*;
#(
  parameter int unsigned T_RP  = 2,
  parameter int unsigned T_RFC = 7,
  parameter int unsigned T_MRD = 3
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  sdram_cmd_decoder_if.slave  bus,
  output logic                cmd_valid,
  output logic [2:0]          cmd_code,
  output logic                init_seen,
  output logic [ADDR_W-1:0]   mode_reg,
  output logic [AR_CNT_W-1:0] ar_cnt,
  output logic [NBANK-1:0]    bank_open,
  output logic                viol,
  output logic [2:0]          viol_code
);

  cmd_dec_t            dec_c;
  logic                tmr_load_c, tmr_busy;
  logic [TMR_W-1:0]    tmr_val_c;

  init_state_e         state_q, state_d;
  logic                cmd_valid_q, cmd_valid_d;
  cmd_code_e           cmd_code_q, cmd_code_d;
  logic                init_seen_q, init_seen_d;
  logic [ADDR_W-1:0]   mode_reg_q, mode_reg_d;
  logic [AR_CNT_W-1:0] ar_cnt_q, ar_cnt_d;
  logic [NBANK-1:0]    bank_open_q, bank_open_d;
  logic                viol_q, viol_d;
  viol_code_e          viol_code_q, viol_code_d;
  logic                seq_err, no_row, row_open, ar_open, timing_err;

  assign dec_c = decode_cmd(bus.cmd);

  // Timer reload for the commands that impose a minimum gap.
  always_comb begin
    tmr_load_c = 1'b0;
    tmr_val_c  = '0;
    if (dec_c.valid) begin
      case (dec_c.code)
        CC_PRE:  begin tmr_load_c = 1'b1; tmr_val_c = TMR_W'(T_RP - 1);  end
        CC_AR:   begin tmr_load_c = 1'b1; tmr_val_c = TMR_W'(T_RFC - 1); end
        CC_MRS:  begin tmr_load_c = 1'b1; tmr_val_c = TMR_W'(T_MRD - 1); end
        default: ;
      endcase
    end
  end

  sdram_tmr #(.W(TMR_W)) u_tmr (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .load      (tmr_load_c),
    .load_val  (tmr_val_c),
    .busy      (tmr_busy)
  );

  // Init FSM, bank tracking, refresh counting and violation priority.
  always_comb begin
    state_d     = state_q;
    cmd_valid_d = dec_c.valid;
    cmd_code_d  = cmd_code_q;
    mode_reg_d  = mode_reg_q;
    ar_cnt_d    = ar_cnt_q;
    bank_open_d = bank_open_q;
    viol_d      = 1'b0;
    viol_code_d = viol_code_q;
    seq_err     = 1'b0;
    no_row      = 1'b0;
    row_open    = 1'b0;
    ar_open     = 1'b0;
    timing_err  = dec_c.valid && tmr_busy;

    if (dec_c.valid) begin
      cmd_code_d = dec_c.code;
      if (state_q != S_READY) begin
        // Anything but the expected command is a sequence error; stay put.
        seq_err = 1'b1;
        case (state_q)
          S_PRE: if (dec_c.code == CC_PRE && bus.addr[A10]) begin
                   seq_err = 1'b0;
                   state_d = S_AR1;
                 end
          S_AR1: if (dec_c.code == CC_AR) begin
                   seq_err = 1'b0;
                   state_d = S_AR2;
                 end
          S_AR2: if (dec_c.code == CC_AR) begin
                   seq_err = 1'b0;
                   state_d = S_MRS;
                 end
          S_MRS: if (dec_c.code == CC_MRS) begin
                   seq_err    = 1'b0;
                   mode_reg_d = bus.addr;
                   state_d    = S_READY;
                 end
          default: state_d = S_PRE;
        endcase
      end else begin
        case (dec_c.code)
          CC_ACT: begin
            row_open              = bank_open_q[bus.ba];
            bank_open_d[bus.ba]   = 1'b1;
          end
          CC_RD, CC_WR: no_row = !bank_open_q[bus.ba];
          CC_AR: begin
            ar_open = |bank_open_q;
            if (ar_cnt_q != '1) ar_cnt_d = ar_cnt_q + AR_CNT_W'(1);
          end
          CC_MRS: begin
            row_open   = |bank_open_q;
            mode_reg_d = bus.addr;
          end
          default: ;
        endcase
      end

      if (dec_c.code == CC_PRE) begin
        if (bus.addr[A10]) bank_open_d = '0;
        else               bank_open_d[bus.ba] = 1'b0;
      end
    end

    if (bus.ar_ld) ar_cnt_d = bus.ar_ld_val;

    // Lowest violation code wins.
    viol_d = 1'b1;
    if (timing_err)    viol_code_d = VC_TIMING;
    else if (seq_err)  viol_code_d = VC_SEQ;
    else if (no_row)   viol_code_d = VC_NO_ROW;
    else if (row_open) viol_code_d = VC_ROW_OPEN;
    else if (ar_open)  viol_code_d = VC_AR_OPEN;
    else               viol_d      = 1'b0;

    init_seen_d = (state_d == S_READY);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_PRE;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= CC_PRE;
      init_seen_q <= 1'b0;
      mode_reg_q  <= '0;
      ar_cnt_q    <= '0;
      bank_open_q <= '0;
      viol_q      <= 1'b0;
      viol_code_q <= VC_NONE;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
      init_seen_q <= init_seen_d;
      mode_reg_q  <= mode_reg_d;
      ar_cnt_q    <= ar_cnt_d;
      bank_open_q <= bank_open_d;
      viol_q      <= viol_d;
      viol_code_q <= viol_code_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_code  = cmd_code_q;
  assign init_seen = init_seen_q;
  assign mode_reg  = mode_reg_q;
  assign ar_cnt    = ar_cnt_q;
  assign bank_open = bank_open_q;
  assign viol      = viol_q;
  assign viol_code = viol_code_q;

endmodule
